// File: rtl/ram_wt.sv
// ram_wt: write side of the cpu15 RAM/IO block.
// It owns eight 16-bit RAM words at addresses 0x00-0x07 and the IO64 output
// port at IO_OUT_AD. Every output comes straight from a flop.
//
// Ports:
//   CLK_WT       clock, rising edge active
//   RESET_N      asynchronous active-low reset
//   RAM_WEN      store strobe
//   RAM_AD_IN    store address (8 bits, fully decoded)
//   RAM_IN       store data (16 bits)
//   RAM_0..RAM_7 registered RAM words, read by the read decoder
//   IO64_OUT     registered output-port data
//   IO64_VALID   output-port data valid, held until acknowledged
//   IO64_ACK     external device accepts IO64_OUT
//   WT_BUSY      copy of IO64_VALID
//   WT_ERR       one-cycle pulse flagging a rejected store
module ram_wt #(
    parameter logic [7:0] IO_OUT_AD = 8'h40,
    parameter logic [7:0] IO_IN_AD  = 8'h41
) (
    input  logic        CLK_WT,
    input  logic        RESET_N,
    input  logic        RAM_WEN,
    input  logic [7:0]  RAM_AD_IN,
    input  logic [15:0] RAM_IN,
    output logic [15:0] RAM_0,
    output logic [15:0] RAM_1,
    output logic [15:0] RAM_2,
    output logic [15:0] RAM_3,
    output logic [15:0] RAM_4,
    output logic [15:0] RAM_5,
    output logic [15:0] RAM_6,
    output logic [15:0] RAM_7,
    output logic [15:0] IO64_OUT,
    output logic        IO64_VALID,
    input  logic        IO64_ACK,
    output logic        WT_BUSY,
    output logic        WT_ERR
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ram_q [0:7];
    logic [15:0] ram_d [0:7];
    logic [15:0] io_out_q, io_out_d;
    logic        io_valid_q, io_valid_d;
    logic        err_q, err_d;

    logic        ram_hit_s;
    logic        io_out_hit_s;
    logic        io_in_hit_s;
    logic        unmapped_s;
    logic        busy_reject_s;

    // Address decode of the current store cycle.
    always_comb begin
        ram_hit_s    = RAM_WEN & (RAM_AD_IN[7:3] == 5'b00000);
        io_out_hit_s = RAM_WEN & (RAM_AD_IN == IO_OUT_AD);
        io_in_hit_s  = RAM_WEN & (RAM_AD_IN == IO_IN_AD);
        // Everything else, including 0x08 and 0x48, counts as unmapped.
        unmapped_s   = RAM_WEN & ~ram_hit_s & ~io_out_hit_s;
    end

    // RAM word update; it does not depend on the IO64 state.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            ram_d[i] = (ram_hit_s && (RAM_AD_IN[2:0] == 3'(i))) ? RAM_IN : ram_q[i];
        end
    end

    // IO64 handshake FSM next-state logic, plus the error flag.
    always_comb begin
        state_d       = state_q;
        io_out_d      = io_out_q;
        io_valid_d    = io_valid_q;
        busy_reject_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // IO64_ACK has no effect while nothing is pending.
                if (io_out_hit_s) begin
                    io_out_d   = RAM_IN;
                    io_valid_d = 1'b1;
                    state_d    = ST_SEND;
                end else begin
                    io_valid_d = 1'b0;
                end
            end
            ST_SEND: begin
                if (IO64_ACK) begin
                    if (io_out_hit_s) begin
                        // Accept cycle: the old word is delivered and the new word is presented.
                        io_out_d   = RAM_IN;
                        io_valid_d = 1'b1;
                    end else begin
                        io_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    // The word is still pending, so a new store to the port is refused.
                    busy_reject_s = io_out_hit_s;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                io_valid_d = 1'b0;
            end
        endcase
        err_d = io_in_hit_s | unmapped_s | busy_reject_s;
    end

    // State and output registers.
    always_ff @(posedge CLK_WT or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            io_out_q   <= 16'h0000;
            io_valid_q <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                ram_q[i] <= 16'h0000;
            end
        end else begin
            state_q    <= state_d;
            io_out_q   <= io_out_d;
            io_valid_q <= io_valid_d;
            err_q      <= err_d;
            for (int i = 0; i < 8; i++) begin
                ram_q[i] <= ram_d[i];
            end
        end
    end

    assign RAM_0      = ram_q[0];
    assign RAM_1      = ram_q[1];
    assign RAM_2      = ram_q[2];
    assign RAM_3      = ram_q[3];
    assign RAM_4      = ram_q[4];
    assign RAM_5      = ram_q[5];
    assign RAM_6      = ram_q[6];
    assign RAM_7      = ram_q[7];
    assign IO64_OUT   = io_out_q;
    assign IO64_VALID = io_valid_q;
    assign WT_BUSY    = io_valid_q;
    assign WT_ERR     = err_q;

endmodule

// File: tb/tb_ram_wt.sv
// Testbench for ram_wt. Directed stimulus drives the DUT. A behavioural model
// built from the store and handshake rules predicts every output, and a
// compare process checks the DUT against the model on each falling edge.
// Hand-computed literal checks pin the model itself.
module tb_ram_wt;

    logic        clk;
    logic        rst_n;
    logic        wen;
    logic [7:0]  ad;
    logic [15:0] din;
    logic        ack;
    logic [15:0] ram_o [0:7];
    logic [15:0] io_out;
    logic        io_valid;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    ram_wt dut (
        .CLK_WT     (clk),
        .RESET_N    (rst_n),
        .RAM_WEN    (wen),
        .RAM_AD_IN  (ad),
        .RAM_IN     (din),
        .RAM_0      (ram_o[0]),
        .RAM_1      (ram_o[1]),
        .RAM_2      (ram_o[2]),
        .RAM_3      (ram_o[3]),
        .RAM_4      (ram_o[4]),
        .RAM_5      (ram_o[5]),
        .RAM_6      (ram_o[6]),
        .RAM_7      (ram_o[7]),
        .IO64_OUT   (io_out),
        .IO64_VALID (io_valid),
        .IO64_ACK   (ack),
        .WT_BUSY    (busy),
        .WT_ERR     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state.
    logic [15:0] m_ram [0:7];
    logic [15:0] m_out;
    logic        m_valid;
    logic        m_err;
    int          m_deliv;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: apply the store and handshake rules at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_ram[i] <= 16'h0000;
            m_out   <= 16'h0000;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            if (wen && ad < 8'd8) m_ram[ad[2:0]] <= din;
            // The port takes a new word when nothing is pending or the pending word is acknowledged now.
            if (wen && ad == 8'h40 && (!m_valid || ack)) begin
                m_out   <= din;
                m_valid <= 1'b1;
            end else if (m_valid && ack) begin
                m_valid <= 1'b0;
            end
            if (m_valid && ack) m_deliv <= m_deliv + 1;
            m_err <= (wen && ad >= 8'd8 && ad != 8'h40) ||
                     (wen && ad == 8'h40 && m_valid && !ack);
        end
    end

    initial m_deliv = 0;

    // Compare process: check every output against the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 8; i++) check("cmp_ram", ram_o[i], m_ram[i]);
            check("cmp_io_out", io_out, m_out);
            check("cmp_valid", {15'd0, io_valid}, {15'd0, m_valid});
            check("cmp_busy", {15'd0, busy}, {15'd0, m_valid});
            check("cmp_err", {15'd0, err}, {15'd0, m_err});
        end
    end

    task automatic cyc(input logic w, input logic [7:0] a, input logic [15:0] d, input logic k);
        wen = w;
        ad  = a;
        din = d;
        ack = k;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 8; i++) check(name, ram_o[i], 16'h0000);
        check(name, io_out, 16'h0000);
        check(name, {14'd0, io_valid, busy}, 16'h0000);
        check(name, {15'd0, err}, 16'h0000);
    endtask

    int d0;
    logic [15:0] words [0:3];

    initial begin
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        words[3] = 16'h4444;
        rst_n = 1'b0;
        wen = 1'b0; ad = 8'h00; din = 16'h0000; ack = 1'b0;
        #12;
        check_all_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RAM stores.
        cyc(1'b1, 8'h03, 16'h1234, 1'b0);
        check("ram3_store", ram_o[3], 16'h1234);
        check("ram7_before", ram_o[7], 16'h0000);
        cyc(1'b1, 8'h07, 16'hBEEF, 1'b0);
        check("ram7_store", ram_o[7], 16'hBEEF);
        check("ram3_kept", ram_o[3], 16'h1234);
        cyc(1'b1, 8'h08, 16'hFFFF, 1'b0);
        check("unmapped08_err", {15'd0, err}, 16'h0001);
        check("unmapped08_ram0", ram_o[0], 16'h0000);
        cyc(1'b1, 8'h48, 16'hFFFF, 1'b0);
        check("unmapped48_err", {15'd0, err}, 16'h0001);
        check("unmapped48_valid", {15'd0, io_valid}, 16'h0000);
        cyc(1'b0, 8'h00, 16'h0000, 1'b0);
        check("err_one_cycle", {15'd0, err}, 16'h0000);

        // IO64 handshake: ACK low for 3 cycles, then high.
        cyc(1'b1, 8'h40, 16'hA5A5, 1'b0);
        check("hs_out", io_out, 16'hA5A5);
        check("hs_valid0", {15'd0, io_valid}, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 16'h0000, 1'b0);
            check("hs_valid_hold", {14'd0, io_valid, busy}, 16'h0003);
            check("hs_out_hold", io_out, 16'hA5A5);
        end
        cyc(1'b0, 8'h00, 16'h0000, 1'b1);
        check("hs_done", {14'd0, io_valid, busy}, 16'h0000);

        // Busy reject.
        cyc(1'b1, 8'h40, 16'hA5A5, 1'b0);
        cyc(1'b1, 8'h40, 16'h0001, 1'b0);
        check("rej_out", io_out, 16'hA5A5);
        check("rej_err", {15'd0, err}, 16'h0001);
        cyc(1'b0, 8'h00, 16'h0000, 1'b0);
        check("rej_err_clear", {15'd0, err}, 16'h0000);
        check("rej_valid", {15'd0, io_valid}, 16'h0001);

        // Accept cycle, then stream four words with ACK held high.
        d0 = m_deliv;
        cyc(1'b1, 8'h40, 16'h5A5A, 1'b1);
        check("acc_out", io_out, 16'h5A5A);
        check("acc_valid", {15'd0, io_valid}, 16'h0001);
        check("acc_err", {15'd0, err}, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'h40, words[i], 1'b1);
            check("stream_out", io_out, words[i]);
            check("stream_valid", {15'd0, io_valid}, 16'h0001);
        end
        cyc(1'b0, 8'h00, 16'h0000, 1'b1);
        check("stream_end_valid", {15'd0, io_valid}, 16'h0000);
        check("stream_deliv", 16'(m_deliv - d0), 16'd6);

        // Input-port write.
        cyc(1'b1, 8'h41, 16'hFFFF, 1'b0);
        check("inport_err", {15'd0, err}, 16'h0001);
        check("inport_out", io_out, 16'h4444);
        check("inport_valid", {15'd0, io_valid}, 16'h0000);
        check("inport_ram7", ram_o[7], 16'hBEEF);

        // Asynchronous reset while a transfer is pending.
        cyc(1'b1, 8'h03, 16'h1111, 1'b0);
        cyc(1'b1, 8'h40, 16'hCCCC, 1'b0);
        check("pre_reset_valid", {15'd0, io_valid}, 16'h0001);
        wen = 1'b0; ad = 8'h00; din = 16'h0000;
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_ram3", ram_o[3], 16'h0000);
        check("post_reset_valid", {15'd0, io_valid}, 16'h0000);
        cyc(1'b0, 8'h00, 16'h0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
